// File: rtl/sram_axi_pkg.sv
// Shared IDs, FSM state types and fixed AXI3 field values for the SRAM-to-AXI arbiter.
package sram_axi_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'd0;
    localparam logic [2:0] AXI_PROT  = 3'd0;

    typedef enum logic {
        AR_IDLE,
        AR_SEND
    } ar_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_RESP
    } w_state_t;

endpackage

// File: rtl/sram_axi_arbiter_if.sv
// AXI3 master port bundle; master modport is the arbiter side, slave modport the memory side.
interface sram_axi_arbiter_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_axi_wr_ctrl.sv
// Data-write sequencer: one write in flight, AW and W handshake independently, then wait for B.
module sram_axi_wr_ctrl
    import sram_axi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    input  logic        data_cnt_zero,
    output logic        wr_addr_ok,
    output logic        wr_data_ok,
    output logic        w_idle,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    input  logic        bready
);

    w_state_t    state_q, state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  size_q;
    logic [3:0]  wstrb_q;

    always_comb begin
        state_d    = state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        wr_addr_ok = 1'b0;
        wr_data_ok = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        unique case (state_q)
            W_IDLE: begin
                // Waiting for outstanding data reads keeps data responses in order.
                if (data_req && data_wr && data_cnt_zero && !reset) begin
                    wr_addr_ok = 1'b1;
                    state_d    = W_SEND;
                end
            end
            W_SEND: begin
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d   = W_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    wr_data_ok = 1'b1;
                    state_d    = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (wr_addr_ok) begin
                addr_q  <= data_addr;
                size_q  <= {1'b0, data_size};
                wstrb_q <= data_wstrb;
                wdata_q <= data_wdata;
            end
        end
    end

    assign w_idle = (state_q == W_IDLE);
    assign awaddr = addr_q;
    assign awsize = size_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

endmodule

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI3 master port between inst and data SRAM-like requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin read arbitration; otherwise data reads win ties.
module sram_axi_arbiter
    import sram_axi_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [31:0]       inst_addr,
    input  logic [3:0]        inst_wstrb,
    input  logic [31:0]       inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [3:0]        data_wstrb,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    sram_axi_arbiter_if.master axi
);

    localparam int unsigned     CntW   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

    ar_state_t       ar_state_q, ar_state_d;
    logic [31:0]     ar_addr_q;
    logic [2:0]      ar_size_q;
    logic [3:0]      ar_id_q;
    logic [CntW-1:0] inst_cnt_q, inst_cnt_d, data_cnt_q, data_cnt_d;
    logic            inst_elig, data_elig, grant_inst, grant_data;
    logic            r_inst, r_data, w_idle, wr_addr_ok, wr_data_ok;

    assign inst_elig = (ar_state_q == AR_IDLE) && inst_req && (inst_cnt_q < MaxCnt) && !reset;
    assign data_elig = (ar_state_q == AR_IDLE) && data_req && !data_wr &&
                       (data_cnt_q < MaxCnt) && w_idle && !reset;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_data_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        last_data_q <= 1'b0;
        else if (grant_inst | grant_data) last_data_q <= grant_data;
    end
    assign grant_data = data_elig && (!inst_elig || !last_data_q);
`else
    assign grant_data = data_elig;
`endif
    assign grant_inst = inst_elig && !grant_data;

    always_comb begin
        ar_state_d = ar_state_q;
        case (ar_state_q)
            AR_IDLE: if (grant_inst || grant_data) ar_state_d = AR_SEND;
            AR_SEND: if (axi.arready)              ar_state_d = AR_IDLE;
        endcase
    end

    assign r_inst = axi.rvalid && axi.rready && !axi.rid[0];
    assign r_data = axi.rvalid && axi.rready && axi.rid[0];

    // Beats arriving with a zero count belong to transactions lost across reset.
    always_comb begin
        inst_cnt_d = inst_cnt_q;
        data_cnt_d = data_cnt_q;
        if (grant_inst && !(r_inst && inst_cnt_q != '0))  inst_cnt_d = inst_cnt_q + 1'b1;
        else if (!grant_inst && r_inst && inst_cnt_q != '0) inst_cnt_d = inst_cnt_q - 1'b1;
        if (grant_data && !(r_data && data_cnt_q != '0))  data_cnt_d = data_cnt_q + 1'b1;
        else if (!grant_data && r_data && data_cnt_q != '0) data_cnt_d = data_cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_state_q <= AR_IDLE;
            ar_addr_q  <= '0;
            ar_size_q  <= '0;
            ar_id_q    <= '0;
            inst_cnt_q <= '0;
            data_cnt_q <= '0;
        end else begin
            ar_state_q <= ar_state_d;
            inst_cnt_q <= inst_cnt_d;
            data_cnt_q <= data_cnt_d;
            if (grant_data) begin
                ar_addr_q <= data_addr;
                ar_size_q <= {1'b0, data_size};
                ar_id_q   <= ID_DATA;
            end else if (grant_inst) begin
                ar_addr_q <= inst_addr;
                ar_size_q <= {1'b0, inst_size};
                ar_id_q   <= ID_INST;
            end
        end
    end

    sram_axi_wr_ctrl u_wr_ctrl (
        .clk           (clk),
        .reset         (reset),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wstrb    (data_wstrb),
        .data_wdata    (data_wdata),
        .data_cnt_zero (data_cnt_q == '0),
        .wr_addr_ok    (wr_addr_ok),
        .wr_data_ok    (wr_data_ok),
        .w_idle        (w_idle),
        .awaddr        (axi.awaddr),
        .awsize        (axi.awsize),
        .awvalid       (axi.awvalid),
        .awready       (axi.awready),
        .wdata         (axi.wdata),
        .wstrb         (axi.wstrb),
        .wvalid        (axi.wvalid),
        .wready        (axi.wready),
        .bvalid        (axi.bvalid),
        .bready        (axi.bready)
    );

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data || wr_addr_ok;
    assign inst_data_ok = r_inst;
    assign data_data_ok = r_data || wr_data_ok;
    assign inst_rdata   = axi.rdata;
    assign data_rdata   = axi.rdata;

    assign axi.arid    = ar_id_q;
    assign axi.araddr  = ar_addr_q;
    assign axi.arsize  = ar_size_q;
    assign axi.arvalid = (ar_state_q == AR_SEND);
    assign axi.arlen   = AXI_LEN;
    assign axi.arburst = AXI_BURST;
    assign axi.arlock  = AXI_LOCK;
    assign axi.arcache = AXI_CACHE;
    assign axi.arprot  = AXI_PROT;
    assign axi.rready  = !reset;

    assign axi.awid    = ID_DATA;
    assign axi.awlen   = AXI_LEN;
    assign axi.awburst = AXI_BURST;
    assign axi.awlock  = AXI_LOCK;
    assign axi.awcache = AXI_CACHE;
    assign axi.awprot  = AXI_PROT;
    assign axi.wid     = ID_DATA;
    assign axi.wlast   = 1'b1;
    // Hold off B while a data R beat is presented so data_data_ok pulses once per cycle.
    assign axi.bready  = !reset && !(axi.rvalid && axi.rid[0]);

    logic unused_ok;
    assign unused_ok = ^{inst_wr, inst_wstrb, inst_wdata, axi.rid[3:1], axi.rresp, axi.rlast,
                         axi.bid, axi.bresp};

endmodule

// File: doc/sram_axi_arbiter.md
# sram_axi_arbiter

Shares one AXI3 master port between the instruction and data SRAM-like requesters of the pipeline.

- Inst reads, data reads and data writes are sequenced onto AR/R, AW/W/B.
- Each transaction is tagged by ARID/AWID so R beats route back to the correct requester.
- Data-side responses stay in request order.
- Sits between the IF/MEM stages and the CPU top-level AXI port.

## Interface
- MAX_OUTSTANDING, 2, max in-flight reads per requester.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- inst_req/inst_wr  in  1  inst SRAM-like request; inst_wr is always 0 and ignored.
- inst_size  in  2  00 byte, 01 half, 10 word.
- inst_addr  in  32  request address.
- inst_wstrb/inst_wdata  in  4/32  ignored.
- inst_addr_ok/inst_data_ok  out  1  request accepted / read data returned.
- inst_rdata  out  32  read data.
- data_req/data_wr/data_size/data_addr/data_wstrb/data_wdata  in  1/1/2/32/4/32  data SRAM-like request.
- data_addr_ok/data_data_ok  out  1  handshake.
- data_rdata  out  32  read data.
- arid/araddr/arsize/arvalid  out  4/32/3/1  AR channel; arready in 1.
- arlen/arburst/arlock/arcache/arprot  out  8/2/2/4/3  tied 0/01/0/0/0.
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready out 1.
- awid/awaddr/awsize/awvalid  out  4/32/3/1; awready in 1; AW len/burst/lock/cache/prot tied as AR.
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready in 1; wid=1, wlast=1.
- bid/bresp/bvalid  in  4/2/1; bready out 1.

## Operation
- IDs: inst = 0, data = 1. Decode uses only rid[0]. rresp/bresp are ignored.
- Read FSM states: AR_IDLE, AR_SEND.
  - Requests are eligible only in AR_IDLE.
  - Inst read is eligible when inst_req and inst_cnt < MAX_OUTSTANDING.
  - Data read is eligible when data_req & ~data_wr, data_cnt < MAX_OUTSTANDING, and the write FSM is in W_IDLE.
  - Winner gets addr_ok the same cycle. Its addr, {1'b0,size} and ID are latched; FSM moves to AR_SEND.
  - AR_SEND: arvalid=1 with latched fields held stable; arready → AR_IDLE.
- Write FSM states: W_IDLE, W_SEND, W_RESP.
  - Data write is accepted in W_IDLE when data_req & data_wr and data_cnt == 0. data_addr_ok asserts; addr, size, wstrb, wdata are latched; FSM moves to W_SEND.
  - W_SEND: awvalid and wvalid asserted. Each drops independently after its handshake. Both done → W_RESP.
  - W_RESP: bvalid & bready → data_data_ok pulse, → W_IDLE.
- Ordering rule: data read blocked while a write is in flight; data write blocked while data reads are outstanding. This gives in-order data responses and no read-after-write hazard.
- R routing: rready=1. rvalid & rid[0]=0 → inst_data_ok, inst_rdata=rdata. rid[0]=1 → data_data_ok, data_rdata=rdata.
- bready = ~(rvalid & rid[0]). A B response colliding with a data R beat waits one cycle, so data_data_ok is a single pulse per cycle.
- Counters inst_cnt/data_cnt, width $clog2(MAX_OUTSTANDING+1):
  - +1 on addr_ok, −1 on the matching R beat.
  - Simultaneous +1 and −1 leaves the count unchanged.
  - Never exceed MAX_OUTSTANDING.
- Inst read and data write may both be accepted in the same cycle. At most one data_addr_ok per cycle.

## Timing
- Reset: both FSMs idle, counters 0, latched fields 0. arvalid, awvalid, wvalid, all addr_ok and data_ok are 0. rready and bready are 0 while reset is high.
- addr_ok is combinational from req in an idle FSM.
- arvalid/awvalid/wvalid rise the cycle after addr_ok.
- data_ok/rdata are combinational from rvalid/bvalid; no buffering.
- Minimum read latency: req at T, arvalid at T+1, earliest data_ok at T+2.
- Reset asserted mid-transaction aborts immediately; in-flight AXI responses after deassert are not tracked.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both reads are eligible, the one not granted last wins. The last-grant flop resets to inst, so data wins the first tie.
- Undefined: data read always beats inst read.

## Structure
- Package sram_axi_pkg holds:
  - ID_INST/ID_DATA
  - ar_state_t and w_state_t enums
  - fixed AXI field constants (LEN, BURST, LOCK, CACHE, PROT)
- Sub-module sram_axi_wr_ctrl holds the write FSM and AW/W/B logic. It exports a w_idle signal.

## Test plan
- inst read 0x1c000000 alone, arready=1, rvalid+rid=0 two cycles later, rdata=0x02800000 → inst_data_ok one cycle, inst_rdata=0x02800000, data_data_ok=0.
- Simultaneous inst and data read in AR_IDLE → data gets addr_ok and arid=1. With ARB_ROUND_ROBIN_EN, a second tie is granted to inst.
- Data write addr 0x100, wdata 0xdeadbeef, wstrb 0xf; awready delayed 3 cycles, wready immediate → wvalid drops first, awvalid held. B response gives a single data_data_ok. Data read to 0x100 gets no addr_ok until the write completes.
- Three back-to-back inst reads with arready=1 and no R → third not granted (MAX_OUTSTANDING=2) until one R returns.
- bvalid and rvalid(rid=1) in the same cycle → bready=0 that cycle and read data_ok first. Write data_ok follows the next cycle.
- Reset asserted while AR_SEND and W_SEND are active → arvalid/awvalid/wvalid=0 immediately, counters 0.
